// File: rtl/wm8731_i2c_target_pkg.sv
// Shared types and constants for the WM8731 control-port I2C target.
package wm8731_i2c_target_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_DATA_H,
    S_ACK_H,
    S_DATA_L,
    S_ACK_L,
    S_WAIT_STOP,
    S_IGNORE
  } state_t;

  localparam logic [6:0] WM8731_ADDR = 7'h1A;

  localparam logic [6:0] REG_LLIN   = 7'h00;
  localparam logic [6:0] REG_RLIN   = 7'h01;
  localparam logic [6:0] REG_LHPOUT = 7'h02;
  localparam logic [6:0] REG_RHPOUT = 7'h03;
  localparam logic [6:0] REG_AAPC   = 7'h04;
  localparam logic [6:0] REG_DAPC   = 7'h05;
  localparam logic [6:0] REG_PDC    = 7'h06;
  localparam logic [6:0] REG_DAIF   = 7'h07;
  localparam logic [6:0] REG_SR     = 7'h08;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  function automatic logic is_ack_state(input state_t s);
    return (s == S_ACK_A) || (s == S_ACK_H) || (s == S_ACK_L);
  endfunction

endpackage

// File: rtl/wm8731_i2c_target_bus_sync.sv
// SCL/SDA synchroniser with registered START/STOP and SCL edge detection.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic scl_d1_q, sda_d1_q;
  logic start_q, stop_q, rise_q, fall_q;
  logic scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Events are registered so they line up with the delayed SDA level in sda_d1_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d1_q   <= 1'b1;
      sda_d1_q   <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_d1_q   <= scl_s;
      sda_d1_q   <= sda_s;
      start_q    <= scl_s & scl_d1_q & sda_d1_q & ~sda_s;
      stop_q     <= scl_s & scl_d1_q & ~sda_d1_q & sda_s;
      rise_q     <= scl_s & ~scl_d1_q;
      fall_q     <= ~scl_s & scl_d1_q;
    end
  end

  assign sda_o   = sda_d1_q;
  assign start_o = start_q;
  assign stop_o  = stop_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/wm8731_i2c_target.sv
// WM8731 control-port I2C target: acknowledges 3-byte writes and decodes register address/value.
module wm8731_i2c_target
  import wm8731_i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = WM8731_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        pkt_valid,
  output logic [23:0] pkt_data,
  output logic [6:0]  reg_addr,
  output logic [8:0]  reg_data,
  output logic        pkt_err,
  output logic        busy
);

  logic sda_s, start_ev, stop_ev, rise_ev, fall_ev;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .sda_o  (sda_s),
    .start_o(start_ev),
    .stop_o (stop_ev),
    .rise_o (rise_ev),
    .fall_o (fall_ev)
  );

  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  hi_q, hi_d;
  logic        ack_drv_q, ack_drv_d;
  logic        overrun_q, overrun_d;
  logic [23:0] pkt_data_q, pkt_data_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic        pkt_err_q, pkt_err_d;
  logic [7:0]  byte_w;

  assign byte_w = {shreg_q[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      hi_q        <= '0;
      ack_drv_q   <= 1'b0;
      overrun_q   <= 1'b0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      hi_q        <= hi_d;
      ack_drv_q   <= ack_drv_d;
      overrun_q   <= overrun_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    hi_d        = hi_q;
    ack_drv_d   = ack_drv_q;
    overrun_d   = overrun_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = 1'b0;
    pkt_err_d   = 1'b0;

    if (start_ev) begin
      if (state_q != S_IDLE && state_q != S_WAIT_STOP && state_q != S_IGNORE) begin
        pkt_err_d = 1'b1;
      end
      state_d   = S_ADDR;
      bitcnt_d  = '0;
      ack_drv_d = 1'b0;
      overrun_d = 1'b0;
    end else if (stop_ev) begin
      unique case (state_q)
        S_IDLE, S_IGNORE: ;
        S_WAIT_STOP: begin
          // shreg_q still holds the low byte: WAIT_STOP counts bits without shifting.
          if (overrun_q) begin
            pkt_err_d = 1'b1;
          end else begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = {DEV_ADDR, 1'b0, hi_q, shreg_q};
          end
        end
        default: pkt_err_d = 1'b1;
      endcase
      state_d   = S_IDLE;
      bitcnt_d  = '0;
      ack_drv_d = 1'b0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_DATA_H, S_DATA_L: begin
          if (rise_ev) begin
            shreg_d  = byte_w;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              unique case (state_q)
                S_ADDR:   state_d = (byte_w == {DEV_ADDR, 1'b0}) ? S_ACK_A : S_IGNORE;
                S_DATA_H: begin
                  hi_d    = byte_w;
                  state_d = S_ACK_H;
                end
                default:  state_d = S_ACK_L;
              endcase
            end
          end
        end
        S_ACK_A, S_ACK_H, S_ACK_L: begin
          // First SCL fall starts driving the ACK, the fall after the 9th clock ends it.
          if (fall_ev) begin
            if (!ack_drv_q) begin
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              unique case (state_q)
                S_ACK_A: state_d = S_DATA_H;
                S_ACK_H: state_d = S_DATA_L;
                default: state_d = S_WAIT_STOP;
              endcase
            end
          end
        end
        S_WAIT_STOP: begin
          if (rise_ev) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              overrun_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sda_oe    = is_ack_state(state_q) & ack_drv_q;
    busy      = (state_q != S_IDLE);
    pkt_valid = pkt_valid_q;
    pkt_err   = pkt_err_q;
    pkt_data  = pkt_data_q;
    reg_addr  = pkt_data_q[15:9];
    reg_data  = pkt_data_q[8:0];
  end

endmodule

// File: doc/wm8731_i2c_target.md
Name: wm8731_i2c_target

Overview:
Synthesizable I2C target that models the WM8731 control port, i.e. the responder for the controller's 24-bit I2C write packets. It oversamples SCL/SDA on the system clock, recognises START/STOP, and acknowledges the device address and both data bytes. On each complete 3-byte write terminated by STOP, it decodes the 7-bit register address and 9-bit register value. It sits on the FPGA/bench side of the I2C bus, in place of the codec, for loopback and self-check of the controller.

Parameters:
DEV_ADDR, 7'h1A, 7-bit target address (WM8731 with CSB=0).
SYNC_STAGES, 2, input synchroniser depth for SCL/SDA (minimum 2).

Ports:
clk  in  1  system clock, 50 MHz.
rst_n  in  1  asynchronous active-low reset.
scl_i  in  1  bus SCL (open-drain, pulled up).
sda_i  in  1  bus SDA read-back.
sda_oe  out  1  1 = drive SDA low (ACK); 0 = release.
pkt_valid  out  1  one-cycle pulse: a complete, acknowledged packet was received.
pkt_data  out  24  {addr byte, hi byte, lo byte}; valid and held from pkt_valid until the next pkt_valid.
reg_addr  out  7  pkt_data[15:9].
reg_data  out  9  pkt_data[8:0].
pkt_err  out  1  one-cycle pulse on an aborted or illegal transaction.
busy  out  1  high from START until STOP.

Behaviour:
- Reset (async, rst_n=0):
  - sda_oe=0, pkt_valid=0, pkt_err=0, busy=0, pkt_data=0, reg_addr=0, reg_data=0.
  - State is IDLE and synchroniser flops are set to 1.
  - SDA is released immediately, with no clock needed.
- Synchronisation:
  - scl_i/sda_i pass through SYNC_STAGES flops, then one extra flop for edge detection.
  - Bus events are seen 3 clk cycles after the pin change (default).
- Event detection on synchronised signals:
  - START: SDA 1->0 while SCL=1.
  - STOP: SDA 0->1 while SCL=1.
  - rise/fall: SCL edges.
  - Data is sampled on SCL rise. SDA changes while SCL=1 are events only, never data.
- Bit counter: 3 bits, cleared on START and at each byte boundary. A byte is shifted MSB-first into an 8-bit register.
- States:
  - IDLE: busy=0. START -> ADDR.
  - ADDR: after 8 bits:
    - byte == {DEV_ADDR,0} -> ACK_A.
    - Any other address, or R/W=1 -> NACK, go to IGNORE (no sda_oe).
  - ACK_A / ACK_H / ACK_L:
    - sda_oe asserts on the SCL fall after bit 8 and holds through the 9th SCL high.
    - It releases on the next SCL fall.
    - Then ACK_A -> DATA_H, ACK_H -> DATA_L, ACK_L -> WAIT_STOP.
  - DATA_H / DATA_L: collect 8 bits -> the matching ACK state.
  - WAIT_STOP:
    - STOP -> latch pkt_data/reg_addr/reg_data, pulse pkt_valid the same cycle, -> IDLE.
    - Further bytes are NACKed (sda_oe stays 0) and a 4th byte clocked in sets a sticky overrun flag.
    - If overrun: STOP pulses pkt_err instead of pkt_valid, with outputs unchanged.
  - IGNORE: STOP -> IDLE.
- START from any state other than IDLE (repeated START):
  - Partial data is discarded and the state goes to ADDR.
  - pkt_err pulses if the state was ADDR, DATA_H, DATA_L, or an ACK state before ACK_L completion.
- STOP in ADDR, DATA_H, DATA_L or an ACK state: discard, pkt_err pulse, sda_oe=0, -> IDLE.
- busy: 1 from START detection to STOP detection inclusive of the STOP cycle; 0 in the cycle after.
- pkt_valid and pkt_err are never high together.
- sda_oe is never asserted while SCL is high except during the 9th-bit ACK window. It is forced 0 in IDLE/IGNORE.

Decomposition:
- Shared package holds:
  - State enum (IDLE, ADDR, ACK_A, DATA_H, ACK_H, DATA_L, ACK_L, WAIT_STOP, IGNORE).
  - WM8731 default address 7'h1A.
  - Register-address constants (e.g. RESET=7'h0F, ACTIVE=7'h09).
- One sub-module, i2c_bus_sync: SCL/SDA synchroniser plus START/STOP/rise/fall detection. The FSM stays in the top.

Test Plan:
- Write 24'h34_0E_4A then STOP -> three ACKs (SDA low on 9th clocks); pkt_valid one pulse; pkt_data=24'h340E4A, reg_addr=7'h07, reg_data=9'h04A.
- Write 24'h34_1E_00 -> reg_addr=7'h0F, reg_data=9'h000. Follow with 24'h36_12_34 (wrong address) -> no ACK on byte 0, no pkt_valid, pkt_data still 24'h341E00, pkt_err=0.
- Read attempt, address byte 8'h35 -> NACK; IGNORE until STOP; no outputs change.
- STOP after byte 2 of 24'h34_0E_4A -> pkt_err pulse, pkt_valid never asserted, sda_oe=0, busy=0 next cycle.
- Repeated START after byte 1, then full 24'h34_10_01 -> one pkt_err, then pkt_valid with reg_addr=7'h08, reg_data=9'h001.
- rst_n low during ACK of byte 2 -> sda_oe drops asynchronously. After release, a fresh 24'h34_0E_4A completes normally.
